// File: rtl/nf10_axis_pkt_gen_pkg.sv
// Shared types and constants for the AXI4-Stream test packet generator.
package nf10_axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  localparam logic [15:0] MIN_LEN = 16'd60;
  localparam logic [15:0] MAX_LEN = 16'd9600;

  // NetFPGA-10G tuser field offsets
  localparam int unsigned TUSER_LEN_LSB = 0;
  localparam int unsigned TUSER_SRC_LSB = 16;
  localparam int unsigned TUSER_DST_LSB = 24;

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    if (len < MIN_LEN) return MIN_LEN;
    if (len > MAX_LEN) return MAX_LEN;
    return len;
  endfunction

  // Only valid for clamped lengths, so len + 7 cannot overflow
  function automatic logic [15:0] len_to_beats(input logic [15:0] len);
    return (len + 16'd7) >> 3;
  endfunction

endpackage

// File: rtl/nf10_axis_pkt_gen_if.sv
// AXI4-Stream bus carrying NetFPGA-10G style tuser metadata.
interface nf10_axis_pkt_gen_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (
    output tdata, tstrb, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tuser, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/nf10_axis_strb_gen.sv
// Byte-enable mask for the final beat of a packet.
module nf10_axis_strb_gen (
  input  logic [2:0] len_lo_i,
  output logic [7:0] strb_o
);
  // Low len_lo bytes valid; a multiple of 8 fills the whole beat
  always_comb begin
    strb_o = 8'hFF;
    if (len_lo_i != 3'd0) strb_o = (8'd1 << len_lo_i) - 8'd1;
  end
endmodule

// File: rtl/nf10_axis_pkt_gen.sv
// AXI4-Stream test packet generator: emits numbered packets with deterministic payload.
module nf10_axis_pkt_gen
  import nf10_axis_pkt_gen_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0]  C_SRC_PORT           = 8'h01,
  parameter logic [7:0]  C_DST_PORT           = 8'h04
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic                       start,
  input  logic                       stop,
  input  logic [15:0]                cfg_pkt_len,
  input  logic [31:0]                cfg_pkt_count,
  input  logic [15:0]                cfg_ifg,
  nf10_axis_pkt_gen_if.master        m_axis,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                pkts_sent
);

  localparam int unsigned StrbW = C_M_AXIS_DATA_WIDTH / 8;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] beats_q, beats_d;
  logic [31:0] count_q, count_d;
  logic [15:0] ifg_q, ifg_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] pkts_q, pkts_d;
  logic        stop_pend_q, stop_pend_d;
  logic        done_q, done_d;

  logic                            valid;
  logic                            last_beat;
  logic                            xfer;
  logic [7:0]                      last_strb;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  raw_data;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  tdata_w;
  logic [StrbW-1:0]                tstrb_w;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_w;

  assign valid     = (state_q == StSend);
  assign last_beat = (beat_q == beats_q - 16'd1);
  assign xfer      = valid & m_axis.tready;
  assign raw_data  = {pkts_q, 16'd0, beat_q};

  nf10_axis_strb_gen u_strb_gen (
    .len_lo_i (len_q[2:0]),
    .strb_o   (last_strb)
  );

  // Next-state: run control, beat/gap counters and stop-at-boundary handling
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beats_d     = beats_q;
    count_d     = count_q;
    ifg_d       = ifg_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    pkts_d      = pkts_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d = StSend;
          len_d   = clamp_len(cfg_pkt_len);
          beats_d = len_to_beats(len_d);
          count_d = cfg_pkt_count;
          ifg_d   = cfg_ifg;
          beat_d  = 16'd0;
          pkts_d  = 32'd0;
        end
      end
      StSend: begin
        if (stop) stop_pend_d = 1'b1;
        if (xfer) begin
          if (last_beat) begin
            beat_d = 16'd0;
            pkts_d = pkts_q + 32'd1;
            if ((count_q != 32'd0 && pkts_d == count_q) || stop || stop_pend_q) begin
              state_d     = StIdle;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end else if (ifg_q != 16'd0) begin
              state_d = StGap;
              gap_d   = ifg_q - 16'd1;
            end
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      StGap: begin
        if (stop || stop_pend_q) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else if (gap_q == 16'd0) begin
          state_d = StSend;
        end else begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q     <= StIdle;
      len_q       <= '0;
      beats_q     <= '0;
      count_q     <= '0;
      ifg_q       <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      pkts_q      <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beats_q     <= beats_d;
      count_q     <= count_d;
      ifg_q       <= ifg_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      pkts_q      <= pkts_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // Bus fields decoded from registers only; forced to zero while not valid
  always_comb begin
    tstrb_w = '0;
    tdata_w = '0;
    tuser_w = '0;
    if (valid) begin
      tstrb_w = last_beat ? last_strb : '1;
      for (int i = 0; i < StrbW; i++) begin
        if (tstrb_w[i]) tdata_w[i*8 +: 8] = raw_data[i*8 +: 8];
      end
      tuser_w[TUSER_LEN_LSB +: 16] = len_q;
      tuser_w[TUSER_SRC_LSB +: 8]  = C_SRC_PORT;
      tuser_w[TUSER_DST_LSB +: 8]  = C_DST_PORT;
    end
  end

  assign m_axis.tvalid = valid;
  assign m_axis.tlast  = valid & last_beat;
  assign m_axis.tstrb  = tstrb_w;
  assign m_axis.tdata  = tdata_w;
  assign m_axis.tuser  = tuser_w;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign pkts_sent     = pkts_q;

endmodule

// File: tb/tb_nf10_axis_pkt_gen.sv
// Scoreboard bench for nf10_axis_pkt_gen: expected beats queued by stimulus, popped by monitor.
module tb_nf10_axis_pkt_gen;

  typedef struct packed {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic        axi_aclk = 1'b0;
  logic        axi_resetn;
  logic        start, stop;
  logic [15:0] cfg_pkt_len;
  logic [31:0] cfg_pkt_count;
  logic [15:0] cfg_ifg;
  logic        busy, done;
  logic [31:0] pkts_sent;

  nf10_axis_pkt_gen_if #(.DATA_W(64), .USER_W(128)) axis_if ();

  nf10_axis_pkt_gen #(
    .C_M_AXIS_DATA_WIDTH  (64),
    .C_M_AXIS_TUSER_WIDTH (128),
    .C_SRC_PORT           (8'h01),
    .C_DST_PORT           (8'h04)
  ) dut (
    .axi_aclk      (axi_aclk),
    .axi_resetn    (axi_resetn),
    .start         (start),
    .stop          (stop),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_pkt_count (cfg_pkt_count),
    .cfg_ifg       (cfg_ifg),
    .m_axis        (axis_if.master),
    .busy          (busy),
    .done          (done),
    .pkts_sent     (pkts_sent)
  );

  always #5 axi_aclk = ~axi_aclk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  beat_t       exp_q[$];

  // Monitor state, updated only on the falling edge
  int unsigned ns = 0;
  int unsigned hs_total = 0;
  int unsigned idle_busy = 0;
  int unsigned done_cnt = 0;
  int unsigned last_hs_ns = 0;
  int unsigned last_done_ns = 0;
  logic        mon_busy = 1'b0;
  logic        mon_valid = 1'b0;
  logic [31:0] mon_pkts = '0;
  logic        in_pkt = 1'b0;
  logic        held = 1'b0;
  beat_t       held_beat;
  int unsigned rdy_mode = 0;

  function automatic void check(input string name, input logic [255:0] got,
                                input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endfunction

  // Reference model: one packet's worth of expected beats, optionally truncated
  task automatic push_pkt(input int unsigned len_cfg, input int unsigned seq,
                          input int unsigned max_beats);
    int unsigned l, nb, rem;
    beat_t b;
    l  = (len_cfg < 60) ? 60 : (len_cfg > 9600) ? 9600 : len_cfg;
    nb = (l + 7) / 8;
    for (int unsigned k = 0; k < nb && k < max_beats; k++) begin
      rem = l - 8 * k;
      if (rem > 8) rem = 8;
      b.data = {seq, k};
      b.strb = '0;
      for (int unsigned i = 0; i < 8; i++) begin
        if (i < rem) b.strb[i] = 1'b1;
        else b.data[i*8 +: 8] = 8'h00;
      end
      b.user = '0;
      b.user[15:0]  = l[15:0];
      b.user[23:16] = 8'h01;
      b.user[31:24] = 8'h04;
      b.last = (k == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  // tready driver: 0 = always ready, 1 = random 50%, 2 = never ready
  initial begin
    axis_if.tready = 1'b1;
    forever begin
      @(posedge axi_aclk);
      #1;
      if (rdy_mode == 0) axis_if.tready = 1'b1;
      else if (rdy_mode == 1) axis_if.tready = 1'($urandom_range(1, 0));
      else axis_if.tready = 1'b0;
    end
  end

  // Monitor: scoreboard pop on each handshake, stall stability, no mid-packet drop
  always @(negedge axi_aclk) begin
    beat_t got, want;
    ns++;
    got = {axis_if.tdata, axis_if.tstrb, axis_if.tuser, axis_if.tlast};
    mon_busy  = busy;
    mon_valid = axis_if.tvalid;
    mon_pkts  = pkts_sent;
    if (!axi_resetn) begin
      in_pkt = 1'b0;
      held   = 1'b0;
    end else begin
      if (held) begin
        check("stall_hold", {axis_if.tvalid, got}, {1'b1, held_beat});
      end
      if (in_pkt) check("no_valid_drop", axis_if.tvalid, 1'b1);
      if (busy && !axis_if.tvalid) idle_busy++;
      if (done) begin
        done_cnt++;
        last_done_ns = ns;
      end
      if (axis_if.tvalid && axis_if.tready) begin
        hs_total++;
        last_hs_ns = ns;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", got);
        end else begin
          want = exp_q.pop_front();
          check("beat", got, want);
        end
        in_pkt = !axis_if.tlast;
      end
      held = axis_if.tvalid && !axis_if.tready;
      held_beat = got;
    end
  end

  task automatic pulse_start(input int unsigned len, input int unsigned cnt,
                             input int unsigned ifg);
    @(posedge axi_aclk);
    #1;
    cfg_pkt_len   = 16'(len);
    cfg_pkt_count = cnt;
    cfg_ifg       = 16'(ifg);
    start         = 1'b1;
    @(posedge axi_aclk);
    #1;
    start         = 1'b0;
    // Config is sampled only on start; scramble it afterwards
    cfg_pkt_len   = 16'($urandom);
    cfg_pkt_count = $urandom;
    cfg_ifg       = 16'($urandom);
  endtask

  // One run; cnt == 0 means unlimited, stopped during packet stop_at
  task automatic do_run(input int unsigned len, input int unsigned cnt, input int unsigned ifg,
                        input int unsigned mode, input int unsigned stop_at);
    int unsigned npk, idle0, done0, budget;
    npk = (cnt != 0) ? cnt : stop_at + 1;
    for (int unsigned p = 0; p < npk; p++) push_pkt(len, p, 32'hFFFF_FFFF);
    rdy_mode = mode;
    idle0 = idle_busy;
    done0 = done_cnt;
    pulse_start(len, cnt, ifg);
    if (cnt == 0) begin
      budget = 20000;
      while (!(mon_pkts == stop_at && mon_valid) && budget > 0) begin
        @(posedge axi_aclk);
        budget--;
      end
      if (budget == 0) check("stop_wait_timeout", 1'b1, 1'b0);
      repeat (3) @(posedge axi_aclk);
      #1 stop = 1'b1;
      @(posedge axi_aclk);
      #1 stop = 1'b0;
      start = 1'b1;
      cfg_pkt_len = 16'd100;
      @(posedge axi_aclk);
      #1 start = 1'b0;
    end
    budget = 30000;
    while (done_cnt == done0 && budget > 0) begin
      @(posedge axi_aclk);
      budget--;
    end
    if (budget == 0) check("done_timeout", 1'b1, 1'b0);
    repeat (3) @(posedge axi_aclk);
    check("drain", exp_q.size(), 0);
    check("done_pulses", done_cnt - done0, 1);
    check("done_timing", last_done_ns, last_hs_ns + 1);
    check("pkts_sent", mon_pkts, npk);
    check("busy_after", mon_busy, 1'b0);
    check("gap_cycles", idle_busy - idle0, ifg * (npk - 1));
    exp_q.delete();
  endtask

  initial begin
    int unsigned hs0, budget;
    axi_resetn = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cfg_pkt_len = '0;
    cfg_pkt_count = '0;
    cfg_ifg = '0;
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    check("rst_tvalid", axis_if.tvalid, 1'b0);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_pkts", pkts_sent, 32'd0);
    check("rst_bus", {axis_if.tdata, axis_if.tstrb, axis_if.tuser, axis_if.tlast}, '0);
    @(posedge axi_aclk);
    #1 axi_resetn = 1'b1;

    do_run(64, 1, 0, 0, 0);
    do_run(61, 2, 3, 0, 0);
    do_run(10, 1, 0, 0, 0);
    do_run(20000, 1, 0, 0, 0);
    do_run($urandom_range(300, 60), 4, 0, 1, 0);
    do_run(200, 0, 0, 1, 3);
    for (int r = 0; r < 4; r++) begin
      do_run($urandom_range(400, 0), $urandom_range(3, 1), $urandom_range(5, 0), 1, 0);
    end

    // Reset during beat 2 of the second packet
    push_pkt(60, 0, 32'hFFFF_FFFF);
    push_pkt(60, 1, 2);
    rdy_mode = 0;
    hs0 = hs_total;
    pulse_start(60, 3, 0);
    budget = 200;
    while (hs_total < hs0 + 10 && budget > 0) begin
      @(posedge axi_aclk);
      budget--;
    end
    if (budget == 0) check("reset_wait_timeout", 1'b1, 1'b0);
    rdy_mode = 2;
    #1 axi_resetn = 1'b0;
    @(posedge axi_aclk);
    #1 axi_resetn = 1'b1;
    @(negedge axi_aclk);
    check("midrst_tvalid", axis_if.tvalid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_pkts", pkts_sent, 32'd0);
    check("midrst_drain", exp_q.size(), 0);
    exp_q.delete();
    do_run(64, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nf10_axis_pkt_gen.md
Name: nf10_axis_pkt_gen

Overview:
AXI4-Stream packet transmitter that drives the s_axis slave port of a 10G interface instance with framed, self-describing test packets, i.e. the sending end of the interface's AXIS ingress path. It emits a programmed number of packets of programmed length with NetFPGA-10G tuser metadata (length/src/dst) and a configurable inter-packet gap. The payload is deterministic so a downstream checker can validate loopback traffic.

Parameters:
C_M_AXIS_DATA_WIDTH, 64, data bus width in bits; only 64 is supported.
C_M_AXIS_TUSER_WIDTH, 128, tuser width in bits.
C_SRC_PORT, 8'h01, value driven on tuser[23:16].
C_DST_PORT, 8'h04, value driven on tuser[31:24].

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a run (honoured only in IDLE)
stop  in  1  one-cycle pulse; ends the run at the next packet boundary
cfg_pkt_len  in  16  packet length in bytes, sampled on start
cfg_pkt_count  in  32  packets per run, sampled on start; 0 = unlimited
cfg_ifg  in  16  idle cycles between packets, sampled on start
m_axis_tdata  out  64  payload
m_axis_tstrb  out  8  byte enables
m_axis_tuser  out  128  metadata
m_axis_tvalid  out  1  valid
m_axis_tready  in  1  ready
m_axis_tlast  out  1  last beat of packet
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when a run ends
pkts_sent  out  32  packets completed in the current run

Behaviour:
- Reset: all outputs 0; state IDLE; counters and latched config cleared.
- Length clamp at start: len < 60 -> 60; len > 9600 -> 9600. beats = ceil(len/8).
- tuser[15:0] = clamped len, [23:16] = C_SRC_PORT, [31:24] = C_DST_PORT, [127:32] = 0; constant for the whole packet.
- tdata beat k of packet n = {n[31:0], k[31:0]}, where n = pkts_sent at the first beat. Bytes beyond len in the last beat are 0.
- tstrb = 8'hFF except the last beat, which has the low (len mod 8) bits set, or 8'hFF when len mod 8 = 0. tlast is high only on beat beats-1.
- Handshake: a beat transfers on tvalid & tready. Once tvalid is high, tdata/tstrb/tuser/tlast hold until the transfer. tvalid never deasserts mid-packet. tvalid does not depend on tready.
- States: IDLE, SEND, GAP.
  - IDLE: on start (and stop low) latch cfg and go to SEND; tvalid rises the next cycle. start with stop in the same cycle is ignored. start outside IDLE is ignored.
  - SEND: the beat index advances per transfer. When the tlast beat transfers, pkts_sent increments. Then:
    - if the run is complete (count != 0 and pkts_sent+1 = count) or stop is pending: go to IDLE and pulse done.
    - else if ifg = 0: stay in SEND and start the next packet on the next cycle with no bubble.
    - else: go to GAP.
  - GAP: tvalid = 0; count ifg cycles, then go to SEND. A stop received in GAP goes to IDLE and pulses done on the next cycle.
- stop arriving during SEND is latched as pending and honoured after tlast transfers; the current packet is never truncated.
- pkts_sent holds its value in IDLE and clears on the next accepted start; it wraps modulo 2^32 in unlimited mode.
- Backpressure: tready low for any duration stalls with outputs stable. Throughput is 1 beat/cycle with tready high.
- Reset mid-packet: tvalid drops on the next edge. The downstream packet is truncated; this is documented and accepted.
- done and the final tlast transfer: done pulses in the cycle after the final tlast handshake.

Decomposition:
- Shared package: state encoding (IDLE/SEND/GAP), length limits MIN_LEN=60 and MAX_LEN=9600, tuser field offsets (LEN 15:0, SRC 23:16, DST 31:24).
- Optional sub-module nf10_axis_strb_gen: combinational len[2:0] -> last-beat tstrb mask. Everything else stays flat.

Test Plan:
- len=64, count=1, ifg=0, tready=1 -> 8 beats; beat k data {0,k}; tstrb FF on all beats; tlast on beat 7; tuser[31:0]=32'h0401_0040; done 1 cycle after; pkts_sent=1.
- len=61, count=2, ifg=3 -> 8 beats each; last tstrb 8'h1F; exactly 3 tvalid-low cycles between packets; second packet data {1,k}.
- len=10 and len=20000 -> clamped to 60 and 9600; tuser[15:0] = 60 and 9600; 8 and 1200 beats respectively.
- Random tready (50%), count=4, ifg=0 -> held data unchanged while stalled; 4 packets with no gaps; no tvalid drop mid-packet.
- count=0, stop pulsed mid-packet 3 -> packet 3 completes with tlast, then IDLE with done; pkts_sent=4; a start while busy has no effect.
- Reset asserted during beat 2 -> next cycle tvalid=0, busy=0, pkts_sent=0; a fresh start then produces a packet with seq 0.
